// File: rtl/algo_1r1w1p_port_sched.sv
// Shares one 1RW bank between a 1R/1W logical port: reads own the bank, writes park in a FIFO buffer.
// Optional ALGO_1R1W1P_SCHED_ERR_EN adds a sticky protocol-violation flag (err_sticky).
module algo_1r1w1p_port_sched #(
    parameter int WIDTH      = 64,
    parameter int NUMADDR    = 8192,
    parameter int BITADDR    = 13,
    parameter int SRAM_DELAY = 1,
    parameter int BUFDPTH    = 4,
    parameter int BITBUF     = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ready,
    input  logic               write,
    input  logic [BITADDR-1:0] wr_adr,
    input  logic [WIDTH-1:0]   din,
    output logic               wr_full,
    input  logic               read,
    input  logic [BITADDR-1:0] rd_adr,
    output logic               rd_vld,
    output logic [WIDTH-1:0]   rd_dout,
    output logic               t1_readA,
    output logic               t1_writeA,
    output logic [BITADDR-1:0] t1_addrA,
    output logic [WIDTH-1:0]   t1_dinA,
`ifdef ALGO_1R1W1P_SCHED_ERR_EN
    output logic               err_sticky,
`endif
    input  logic [WIDTH-1:0]   t1_doutA
);

    localparam logic [BITADDR-1:0] LAST_ADR = BITADDR'(NUMADDR - 1);
    localparam logic [BITBUF:0]    FULL_CNT = (BITBUF + 1)'(BUFDPTH);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t             state_q;
    logic [BITADDR-1:0] init_cnt_q;
    logic               ready_q;
    logic               wr_full_q;
    logic [BITADDR-1:0] buf_adr_q [BUFDPTH];
    logic [WIDTH-1:0]   buf_dat_q [BUFDPTH];
    logic [BITBUF-1:0]  wr_ptr_q;
    logic [BITBUF-1:0]  rd_ptr_q;
    logic [BITBUF:0]    cnt_q;
    logic [BITBUF:0]    cnt_d;
    logic               vld_q [SRAM_DELAY];
    logic               hit_q [SRAM_DELAY];
    logic [WIDTH-1:0]   fwd_q [SRAM_DELAY];
    logic [WIDTH-1:0]   dout_hold_q;

    logic               in_init;
    logic               active;
    logic               rd_acc;
    logic               hit;
    logic [WIDTH-1:0]   hit_dat;
    logic               bank_rd;
    logic               pop;
    logic               push;
    logic [WIDTH-1:0]   rd_data;

    assign in_init = rst && (state_q == ST_INIT);
    assign active  = rst && (state_q == ST_READY);
    assign rd_acc  = active && read;

    // Walk oldest to youngest so the last match (youngest write) wins.
    always_comb begin
        hit     = 1'b0;
        hit_dat = '0;
        for (int i = 0; i < BUFDPTH; i++) begin
            if (((BITBUF + 1)'(i) < cnt_q) &&
                (buf_adr_q[rd_ptr_q + BITBUF'(i)] == rd_adr)) begin
                hit     = 1'b1;
                hit_dat = buf_dat_q[rd_ptr_q + BITBUF'(i)];
            end
        end
    end

    assign bank_rd = rd_acc && !hit;
    assign pop     = active && !bank_rd && (cnt_q != '0);
    assign push    = active && write && !wr_full_q;
    assign cnt_d   = cnt_q + (BITBUF + 1)'(push) - (BITBUF + 1)'(pop);

    assign t1_readA  = bank_rd;
    assign t1_writeA = pop || in_init;
    assign t1_addrA  = bank_rd ? rd_adr :
                       pop     ? buf_adr_q[rd_ptr_q] :
                       in_init ? init_cnt_q : '0;
    assign t1_dinA   = pop ? buf_dat_q[rd_ptr_q] : '0;

    assign rd_data = hit_q[SRAM_DELAY-1] ? fwd_q[SRAM_DELAY-1] : t1_doutA;
    assign rd_vld  = vld_q[SRAM_DELAY-1];
    assign rd_dout = rd_vld ? rd_data : dout_hold_q;
    assign ready   = ready_q;
    assign wr_full = wr_full_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            ready_q     <= 1'b0;
            wr_full_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            dout_hold_q <= '0;
            for (int k = 0; k < SRAM_DELAY; k++) vld_q[k] <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == LAST_ADR) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q     <= cnt_d;
            wr_full_q <= (cnt_d == FULL_CNT);
            vld_q[0]  <= rd_acc;
            for (int k = 1; k < SRAM_DELAY; k++) vld_q[k] <= vld_q[k-1];
            if (rd_vld) dout_hold_q <= rd_data;
        end
    end

    // Data-only storage: validity is tracked by cnt_q and vld_q.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_adr_q[wr_ptr_q] <= wr_adr;
            buf_dat_q[wr_ptr_q] <= din;
        end
        hit_q[0] <= hit;
        fwd_q[0] <= hit_dat;
        for (int k = 1; k < SRAM_DELAY; k++) begin
            hit_q[k] <= hit_q[k-1];
            fwd_q[k] <= fwd_q[k-1];
        end
    end

`ifdef ALGO_1R1W1P_SCHED_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if ((write && wr_full_q) || ((read || write) && !ready_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_algo_1r1w1p_port_sched.sv
// Directed bench for algo_1r1w1p_port_sched with a behavioural bank and
// queue-based scoreboards for read data and bank writes.
module tb_algo_1r1w1p_port_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [3:0] wr_adr = '0;
    logic [3:0] rd_adr = '0;
    logic [7:0] din = '0;
    logic       ready, wr_full, rd_vld;
    logic [7:0] rd_dout;
    logic       t1_readA, t1_writeA;
    logic [3:0] t1_addrA;
    logic [7:0] t1_dinA;
    logic [7:0] t1_doutA = 8'hFF;
`ifdef ALGO_1R1W1P_SCHED_ERR_EN
    logic       err_sticky;
`endif

    algo_1r1w1p_port_sched #(
        .WIDTH(8), .NUMADDR(16), .BITADDR(4), .SRAM_DELAY(1), .BUFDPTH(4), .BITBUF(2)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .write(write), .wr_adr(wr_adr), .din(din), .wr_full(wr_full),
        .read(read), .rd_adr(rd_adr), .rd_vld(rd_vld), .rd_dout(rd_dout),
        .t1_readA(t1_readA), .t1_writeA(t1_writeA), .t1_addrA(t1_addrA),
        .t1_dinA(t1_dinA),
`ifdef ALGO_1R1W1P_SCHED_ERR_EN
        .err_sticky(err_sticky),
`endif
        .t1_doutA(t1_doutA)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]  rq[$];
    logic [11:0] wq[$];
    logic [7:0]  mem [16] = '{default: 8'hFF};
    logic [7:0]  m_rd;
    logic [11:0] m_wr;

    // Behavioural single-port bank, one cycle read latency.
    always @(posedge clk) begin
        if (t1_writeA) mem[t1_addrA] <= t1_dinA;
        if (t1_readA)  t1_doutA <= mem[t1_addrA];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_vld) begin
            if (rq.size() == 0) begin
                chk("rd_vld_unexpected", 32'(rd_vld), 32'(0));
            end else begin
                m_rd = rq.pop_front();
                chk("rd_dout", 32'(rd_dout), 32'(m_rd));
            end
        end
        if (t1_writeA) begin
            if (wq.size() == 0) begin
                chk("bank_wr_unexpected", 32'({t1_addrA, t1_dinA}), 32'hFFFFF);
            end else begin
                m_wr = wq.pop_front();
                chk("bank_wr", 32'({t1_addrA, t1_dinA}), 32'(m_wr));
            end
        end
        if (t1_readA && t1_writeA) chk("strobe_overlap", 32'(1), 32'(0));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input int ra, input int w, input int wa, input int d);
        read   = r[0];
        rd_adr = 4'(ra);
        write  = w[0];
        wr_adr = 4'(wa);
        din    = 8'(d);
        @(negedge clk);
    endtask

    task automatic exp_rd(input int d);
        rq.push_back(8'(d));
    endtask

    task automatic exp_wr(input int a, input int d);
        wq.push_back({4'(a), 8'(d)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        tick;
        tick;
        @(negedge clk);
        chk("rst_ready",   32'(ready),     32'(0));
        chk("rst_wr_full", 32'(wr_full),   32'(0));
        chk("rst_rd_vld",  32'(rd_vld),    32'(0));
        chk("rst_rd_dout", 32'(rd_dout),   32'(0));
        chk("rst_readA",   32'(t1_readA),  32'(0));
        chk("rst_writeA",  32'(t1_writeA), 32'(0));
        chk("rst_addrA",   32'(t1_addrA),  32'(0));
        chk("rst_dinA",    32'(t1_dinA),   32'(0));
`ifdef ALGO_1R1W1P_SCHED_ERR_EN
        chk("rst_err", 32'(err_sticky), 32'(0));
`endif
        for (int i = 0; i < 16; i++) exp_wr(i, 0);
        tick;
        rst = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("init_ready_low", 32'(ready), 32'(0));
            tick;
        end
        @(negedge clk);
        chk("init_ready_high", 32'(ready), 32'(1));
        tick;

        // Post-init read returns zero from the bank.
        drive(1, 9, 0, 0, 0); exp_rd(0); chk("miss_readA", 32'(t1_readA), 32'(1)); tick;
        drive(0, 0, 0, 0, 0); tick;

        // Single buffered write drains on the next free cycle.
        drive(0, 0, 1, 3, 'hA5); exp_wr(3, 'hA5);
        chk("push_no_bankwr", 32'(t1_writeA), 32'(0)); tick;
        drive(0, 0, 0, 0, 0); chk("drain_writeA", 32'(t1_writeA), 32'(1)); tick;
        drive(0, 0, 0, 0, 0); tick;
        drive(1, 3, 0, 0, 0); exp_rd('hA5); chk("bank_readA", 32'(t1_readA), 32'(1)); tick;
        drive(0, 0, 0, 0, 0); tick;

        // Reads starve the drain; youngest buffered entry is forwarded.
        drive(1, 0, 1, 5, 'h11); exp_rd(0); chk("starve_wr0", 32'(t1_writeA), 32'(0)); tick;
        drive(1, 0, 1, 5, 'h22); exp_rd(0); chk("starve_wr1", 32'(t1_writeA), 32'(0)); tick;
        drive(1, 5, 0, 0, 0); exp_rd('h22); exp_wr(5, 'h11);
        chk("fwd_no_readA", 32'(t1_readA), 32'(0)); tick;
        exp_wr(5, 'h22);
        drive(0, 0, 0, 0, 0); tick;
        drive(0, 0, 0, 0, 0); tick;
`ifdef ALGO_1R1W1P_SCHED_ERR_EN
        chk("err_clean", 32'(err_sticky), 32'(0));
`endif

        // Fill the buffer under continuous reads; fifth write is dropped.
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 1, 8 + k, 'h81 + k);
            exp_rd(0);
            if (k == 3) chk("full_before", 32'(wr_full), 32'(0));
            if (k == 4) chk("full_after",  32'(wr_full), 32'(1));
            if (k < 4) exp_wr(8 + k, 'h81 + k);
            tick;
        end
        drive(0, 0, 0, 0, 0);
`ifdef ALGO_1R1W1P_SCHED_ERR_EN
        chk("err_set", 32'(err_sticky), 32'(1));
`endif
        tick;
        repeat (3) begin drive(0, 0, 0, 0, 0); tick; end
        drive(0, 0, 0, 0, 0); chk("full_cleared", 32'(wr_full), 32'(0)); tick;
        drive(1, 12, 0, 0, 0); exp_rd(0); tick;
        drive(0, 0, 0, 0, 0); tick;

        // Same-cycle read/write to one address: read sees old data, next read is forwarded.
        drive(1, 7, 1, 7, 'h5A); exp_rd(0); chk("same_cyc_readA", 32'(t1_readA), 32'(1)); tick;
        drive(1, 7, 0, 0, 0); exp_rd('h5A); exp_wr(7, 'h5A);
        chk("same_cyc_fwd", 32'(t1_readA), 32'(0)); tick;
        drive(0, 0, 0, 0, 0); tick;

        // Reset with three entries buffered and a read issued on the reset edge.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 1 + k, 'h31 + k); exp_rd(0); tick;
        end
        rst = 1'b0;
        drive(1, 4, 0, 0, 0); chk("rst_kill_readA", 32'(t1_readA), 32'(0)); tick;
        drive(0, 0, 0, 0, 0);
        chk("rst2_rd_vld",  32'(rd_vld),  32'(0));
        chk("rst2_wr_full", 32'(wr_full), 32'(0));
        chk("rst2_ready",   32'(ready),   32'(0));
`ifdef ALGO_1R1W1P_SCHED_ERR_EN
        chk("rst2_err", 32'(err_sticky), 32'(0));
`endif
        for (int i = 0; i < 16; i++) exp_wr(i, 0);
        tick;
        rst = 1'b1;
        repeat (16) tick;
        @(negedge clk);
        chk("reinit_ready", 32'(ready), 32'(1));
        tick;
        drive(1, 1, 0, 0, 0); exp_rd(0); tick;
        drive(1, 2, 0, 0, 0); exp_rd(0); tick;
        drive(1, 3, 0, 0, 0); exp_rd(0); tick;
        drive(0, 0, 0, 0, 0); tick;
        repeat (3) tick;
        @(negedge clk);
        chk("rd_queue_empty", 32'(rq.size()), 32'(0));
        chk("wr_queue_empty", 32'(wq.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
